hero_write_arb: RTL

- Parametrised N-channel aggregator for hero write traffic. Each beat carries a cycle type (IDLE/VALID/DONE), HERO_WIDTH data and clk_en.
- Buffers each input channel in its own FIFO and arbitrates round-robin onto one registered output bus.
- Locks the grant for a whole transaction (VALID* then DONE), so transactions never interleave.
- Sits between multiple hero write sources and the single hero bus around the bag.

---
 rtl/hero_write_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hero_write_arb.sv
// hero_write_arb: N-channel hero write aggregator. Each channel is buffered in
// its own FIFO. A round-robin arbiter then merges the channels onto one
// registered output bus. The grant stays locked to a channel from its first
// beat until its DONE beat, so transactions never interleave.
module hero_write_arb #(
    parameter int NUM_CH     = 4,
    parameter int HERO_WIDTH = 36,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH*4-1:0]          in_cycle_type,
    input  logic [NUM_CH*HERO_WIDTH-1:0] in_wdat,
    input  logic [NUM_CH-1:0]            in_clk_en,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [3:0]                   out_cycle_type,
    output logic [HERO_WIDTH-1:0]        out_wdat,
    output logic                         out_clk_en,
    output logic [CH_W-1:0]              out_ch_id,
    input  logic                         out_ready,
    output logic [NUM_CH-1:0]            err_illegal
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // FIFO entry layout: {last, wdat, clk_en}
    localparam int EW = HERO_WIDTH + 2;

    localparam logic [3:0] CT_IDLE  = 4'd0;
    localparam logic [3:0] CT_VALID = 4'd1;
    localparam logic [3:0] CT_DONE  = 4'd2;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_illegal;
    logic [NUM_CH-1:0] w_pop;
    logic [EW-1:0]     w_head [NUM_CH];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CH_W-1:0] r_lock_ch;
    logic [CH_W-1:0] w_lock_ch_nxt;
    logic [CH_W-1:0] r_last;
    logic [CH_W-1:0] w_last_nxt;

    logic            w_load;
    logic            w_take;
    logic            w_scan_vld;
    logic [CH_W-1:0] w_scan_ch;
    logic [CH_W-1:0] w_cand;
    logic            w_gnt_vld;
    logic [CH_W-1:0] w_gnt_ch;
    logic [EW-1:0]   w_gnt_beat;
    logic            w_gnt_last;

    logic [3:0]            r_out_type;
    logic [HERO_WIDTH-1:0] r_out_wdat;
    logic                  r_out_ce;
    logic [CH_W-1:0]       r_out_ch;
    logic [NUM_CH-1:0]     r_err;

    // The output register accepts a new beat when it is empty or being drained.
    assign w_load = (r_out_type == CT_IDLE) || out_ready;
    assign w_take = w_load && w_gnt_vld;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [3:0]    w_type;
        logic [EW-1:0] r_mem [FIFO_DEPTH];
        logic [AW:0]   r_wptr;
        logic [AW:0]   r_rptr;

        assign w_type       = in_cycle_type[c*4 +: 4];
        // Full/empty come only from registered pointers, so a full FIFO refuses
        // a push even when it pops in the same cycle.
        assign w_full[c]    = (r_wptr[AW] != r_rptr[AW]) &&
                              (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        assign w_empty[c]   = (r_wptr == r_rptr);
        assign w_push[c]    = ((w_type == CT_VALID) || (w_type == CT_DONE)) && !w_full[c];
        assign w_illegal[c] = (w_type > CT_DONE) && !w_full[c];
        assign w_pop[c]     = w_take && (w_gnt_ch == CH_W'(c));
        assign w_head[c]    = r_mem[r_rptr[AW-1:0]];

        // Beat storage; contents are only read while the pointers say valid.
        always_ff @(posedge clk) begin
            if (w_push[c]) begin
                r_mem[r_wptr[AW-1:0]] <= {(w_type == CT_DONE),
                                          in_wdat[c*HERO_WIDTH +: HERO_WIDTH],
                                          in_clk_en[c]};
            end
        end

        // Read/write pointers; reset empties the FIFO and drops buffered beats.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push[c]) r_wptr <= r_wptr + 1'b1;
                if (w_pop[c])  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign in_ready = ~w_full;

    // Grant selection: the locked channel only, or round-robin scan after r_last.
    always_comb begin
        w_scan_vld = 1'b0;
        w_scan_ch  = '0;
        w_cand     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = CH_W'((int'(r_last) + i) % NUM_CH);
            if (!w_scan_vld && !w_empty[w_cand]) begin
                w_scan_vld = 1'b1;
                w_scan_ch  = w_cand;
            end
        end
        if (r_state == ST_LOCKED) begin
            w_gnt_ch  = r_lock_ch;
            w_gnt_vld = !w_empty[r_lock_ch];
        end else begin
            w_gnt_ch  = w_scan_ch;
            w_gnt_vld = w_scan_vld;
        end
    end

    assign w_gnt_beat = w_head[w_gnt_ch];
    assign w_gnt_last = w_gnt_beat[EW-1];

    // Next state: lock on a non-final beat from IDLE, unlock on the DONE beat.
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_ch_nxt = r_lock_ch;
        w_last_nxt    = r_last;
        if (w_take) begin
            if (r_state == ST_IDLE) begin
                w_last_nxt = w_gnt_ch;
                if (!w_gnt_last) begin
                    w_state_nxt   = ST_LOCKED;
                    w_lock_ch_nxt = w_gnt_ch;
                end
            end else if (w_gnt_last) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // Arbiter state register; after reset ch0 has first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
            r_last    <= CH_W'(NUM_CH - 1);
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_ch_nxt;
            r_last    <= w_last_nxt;
        end
    end

    // Output register: load a popped beat or a bubble; hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_type <= CT_IDLE;
            r_out_wdat <= '0;
            r_out_ce   <= 1'b0;
            r_out_ch   <= '0;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_out_type <= w_gnt_last ? CT_DONE : CT_VALID;
                r_out_wdat <= w_gnt_beat[HERO_WIDTH:1];
                r_out_ce   <= w_gnt_beat[0];
                r_out_ch   <= w_gnt_ch;
            end else begin
                r_out_type <= CT_IDLE;
            end
        end
    end

    // One-cycle error pulse for an illegal cycle type that was dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= '0;
        else     r_err <= w_illegal;
    end

    assign out_cycle_type = r_out_type;
    assign out_wdat       = r_out_wdat;
    assign out_clk_en     = r_out_ce;
    assign out_ch_id      = r_out_ch;
    assign err_illegal    = r_err;

endmodule
